// File: rtl/ask_symbol_source.sv
// 4-ASK symbol source: alternating preamble followed by PRBS15 Gray-mapped data frames.
// Compile-time option ZERO_STUFF_EN selects impulse upsampling; without it, symbols are sample-and-hold.
module ask_symbol_source #(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned FRAME_LEN    = 256
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               sam_clk_en,
  input  logic               sym_clk_en,
  input  logic               start,
  input  logic               stop,
  output logic signed [17:0] x_out,
  output logic               busy,
  output logic               frame_sync
);

  localparam int unsigned XW     = 18;
  localparam int unsigned LFSR_W = 15;
  localparam int unsigned PCNT_W = 8;
  localparam int unsigned DCNT_W = 16;

  localparam logic [LFSR_W-1:0]   LFSR_SEED = 15'h7FFF;
  localparam logic signed [XW-1:0] POS_HI   = 18'sd98304;
  localparam logic signed [XW-1:0] POS_LO   = 18'sd32768;
  localparam logic signed [XW-1:0] NEG_LO   = -18'sd32768;
  localparam logic signed [XW-1:0] NEG_HI   = -18'sd98304;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PCNT_W-1:0]     pre_cnt_q, pre_cnt_d;
  logic [DCNT_W-1:0]     dat_cnt_q, dat_cnt_d;
  logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
  logic signed [XW-1:0]  x_out_q, x_out_d;
  logic                  busy_q, busy_d;
  logic                  frame_sync_q, frame_sync_d;

  logic                  pre_last_c;
  logic                  dat_last_c;
  logic                  entering_c;
  logic                  bit_a_c, bit_b_c;
  logic [LFSR_W-1:0]     lfsr_a_c, lfsr_b_c;
  logic signed [XW-1:0]  sym_val_c;
  logic                  first_data_c;

  assign pre_last_c = (pre_cnt_q == PCNT_W'(PREAMBLE_LEN - 1));
  assign dat_last_c = (dat_cnt_q == DCNT_W'(FRAME_LEN - 1));

  // Two LFSR steps per data symbol; the first new bit is the symbol MSB.
  assign bit_a_c  = lfsr_q[14] ^ lfsr_q[13];
  assign lfsr_a_c = {lfsr_q[13:0], bit_a_c};
  assign bit_b_c  = lfsr_a_c[14] ^ lfsr_a_c[13];
  assign lfsr_b_c = {lfsr_a_c[13:0], bit_b_c};

  function automatic logic signed [XW-1:0] gray_map(input logic [1:0] bits);
    logic signed [XW-1:0] v;
    v = NEG_HI;
    case (bits)
      2'b00:   v = NEG_HI;
      2'b01:   v = NEG_LO;
      2'b11:   v = POS_LO;
      2'b10:   v = POS_HI;
      default: v = NEG_HI;
    endcase
    return v;
  endfunction

  // State register
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: transitions only on symbol strobes, stop wins over start
  always_comb begin
    state_d = state_q;
    if (sym_clk_en) begin
      if (stop) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE:     if (start) state_d = ST_PREAMBLE;
          ST_PREAMBLE: if (pre_last_c) state_d = ST_DATA;
          ST_DATA:     if (dat_last_c) state_d = start ? ST_PREAMBLE : ST_IDLE;
          default:     state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Symbol decision, counters, LFSR and sample stream
  always_comb begin
    pre_cnt_d    = pre_cnt_q;
    dat_cnt_d    = dat_cnt_q;
    lfsr_d       = lfsr_q;
    x_out_d      = x_out_q;
    frame_sync_d = frame_sync_q;
    busy_d       = (state_d != ST_IDLE);
    sym_val_c    = '0;
    entering_c   = (state_d != state_q);
    first_data_c = 1'b0;

    if (sym_clk_en) begin
      if (entering_c) begin
        pre_cnt_d = '0;
        dat_cnt_d = '0;
      end
      case (state_d)
        ST_PREAMBLE: begin
          if (!entering_c) pre_cnt_d = pre_cnt_q + PCNT_W'(1);
          sym_val_c = pre_cnt_d[0] ? NEG_HI : POS_HI;
        end
        ST_DATA: begin
          if (!entering_c) dat_cnt_d = dat_cnt_q + DCNT_W'(1);
          lfsr_d       = lfsr_b_c;
          sym_val_c    = gray_map({bit_a_c, bit_b_c});
          first_data_c = entering_c;
        end
        default: sym_val_c = '0;
      endcase
    end

    if (sam_clk_en) begin
      if (sym_clk_en) begin
        x_out_d      = sym_val_c;
        frame_sync_d = first_data_c;
      end else begin
`ifdef ZERO_STUFF_EN
        x_out_d      = '0;
`else
        x_out_d      = x_out_q;
`endif
        frame_sync_d = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pre_cnt_q    <= '0;
      dat_cnt_q    <= '0;
      lfsr_q       <= LFSR_SEED;
      x_out_q      <= '0;
      busy_q       <= 1'b0;
      frame_sync_q <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      dat_cnt_q    <= dat_cnt_d;
      lfsr_q       <= lfsr_d;
      x_out_q      <= x_out_d;
      busy_q       <= busy_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  assign x_out      = x_out_q;
  assign busy       = busy_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_ask_symbol_source.sv
// Bench for ask_symbol_source: frame-position reference model checked every cycle on two instances
// (default frame and FRAME_LEN=4), plus hand-computed literal expectations.
module tb_ask_symbol_source;

`ifdef ZERO_STUFF_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic reset = 1'b1;
  logic sam_clk_en = 1'b0;
  logic sym_clk_en = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;

  logic signed [17:0] x_a, x_b;
  logic busy_a, busy_b, fs_a, fs_b;

  int n_cmp = 0;
  int n_err = 0;
  int ph = 0;
  int seq [0:100];

  ask_symbol_source #(.PREAMBLE_LEN(8), .FRAME_LEN(256)) dut_a (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .start(start), .stop(stop), .x_out(x_a), .busy(busy_a), .frame_sync(fs_a));

  ask_symbol_source #(.PREAMBLE_LEN(8), .FRAME_LEN(4)) dut_b (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .start(start), .stop(stop), .x_out(x_b), .busy(busy_b), .frame_sync(fs_b));

  always #5 sys_clk = ~sys_clk;

  // Samples every other cycle, a symbol every fourth sample.
  always @(negedge sys_clk) begin
    ph = (ph + 1) % 8;
    sam_clk_en = (ph % 2 == 0);
    sym_clk_en = (ph == 0);
  end

  // Reference model: position within the preamble+data sequence of the current frame.
  typedef struct {
    bit        active;
    int        pos;
    bit [14:0] lfsr;
    int        cur;
    int        x;
    bit        fs;
  } mdl_t;

  function automatic mdl_t mdl_step(mdl_t m, int plen, int flen,
                                    bit rst, bit sam, bit sym, bit st, bit sp);
    int bits;
    bit b;
    if (rst) begin
      m.active = 0; m.pos = 0; m.lfsr = 15'h7FFF; m.cur = 0; m.x = 0; m.fs = 0;
      return m;
    end
    if (sym) begin
      if (sp) m.active = 0;
      else if (!m.active) begin
        if (st) begin m.active = 1; m.pos = 0; end
      end else begin
        m.pos++;
        if (m.pos == plen + flen) begin
          if (st) m.pos = 0;
          else m.active = 0;
        end
      end
      if (!m.active) m.cur = 0;
      else if (m.pos < plen) m.cur = (m.pos % 2 == 0) ? 98304 : -98304;
      else begin
        bits = 0;
        for (int k = 0; k < 2; k++) begin
          b = m.lfsr[14] ^ m.lfsr[13];
          m.lfsr = {m.lfsr[13:0], b};
          bits = bits * 2 + int'(b);
        end
        case (bits)
          0: m.cur = -98304;
          1: m.cur = -32768;
          3: m.cur = 32768;
          default: m.cur = 98304;
        endcase
      end
    end
    if (sam) begin
      if (sym) begin
        m.x  = m.cur;
        m.fs = m.active && (m.pos == plen);
      end else begin
        m.x  = ZS ? 0 : m.cur;
        m.fs = 0;
      end
    end
    return m;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  mdl_t ma, mb;

  // Every-cycle comparison against the model
  always @(posedge sys_clk) begin
    ma = mdl_step(ma, 8, 256, reset, sam_clk_en, sym_clk_en, start, stop);
    mb = mdl_step(mb, 8, 4, reset, sam_clk_en, sym_clk_en, start, stop);
    #2;
    check("model_a_x", int'(x_a), ma.x);
    check("model_a_busy", int'(busy_a), int'(ma.active));
    check("model_a_fs", int'(fs_a), int'(ma.fs));
    check("model_b_x", int'(x_b), mb.x);
    check("model_b_busy", int'(busy_b), int'(mb.active));
    check("model_b_fs", int'(fs_b), int'(mb.fs));
  end

  task automatic next_sym();
    do @(posedge sys_clk); while (sym_clk_en !== 1'b1);
    #2;
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    @(posedge sys_clk); #2;
    check("rst_x", int'(x_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_fs", int'(fs_a), 0);

    // start and stop together hold IDLE
    @(negedge sys_clk); start = 1'b1; stop = 1'b1;
    next_sym(); next_sym();
    check("startstop_x", int'(x_a), 0);
    check("startstop_busy", int'(busy_a), 0);
    @(negedge sys_clk); stop = 1'b0;

    next_sym();
    check("pre0_x", int'(x_a), 98304);
    check("pre0_busy", int'(busy_a), 1);
    next_sym();
    check("pre1_x", int'(x_a), -98304);
    repeat (6) next_sym();

    for (int d = 0; d <= 100; d++) begin
      next_sym();
      seq[d] = int'(x_a);
      if (d == 0) begin
        check("data0_x", int'(x_a), -98304);
        check("data0_fs", int'(fs_a), 1);
        do @(posedge sys_clk); while (!(sam_clk_en === 1'b1 && sym_clk_en === 1'b0));
        #2;
        check("upsample_x", int'(x_a), ZS ? 0 : -98304);
        check("fs_clear", int'(fs_a), 0);
      end
      if (d == 7)  check("data7_x", int'(x_a), 98304);
      if (d == 4)  check("short_pre_again", int'(x_b), 98304);
      if (d == 12) check("short_fs2", int'(fs_b), 1);
      if (d == 14) check("short_f2d2_x", int'(x_b), -98304);
      if (d == 15) check("short_f2d3_x", int'(x_b), 98304);
    end

    // reset at data symbol 100
    @(negedge sys_clk); reset = 1'b1;
    @(posedge sys_clk); #2;
    check("midrst_x", int'(x_a), 0);
    check("midrst_busy", int'(busy_a), 0);
    check("midrst_b_busy", int'(busy_b), 0);
    @(negedge sys_clk); reset = 1'b0;

    repeat (8) next_sym();
    for (int d = 0; d <= 100; d++) begin
      next_sym();
      check("replay_x", int'(x_a), seq[d]);
    end

    @(negedge sys_clk); stop = 1'b1;
    next_sym();
    check("stop_x", int'(x_a), 0);
    check("stop_busy", int'(busy_a), 0);
    check("stop_b_busy", int'(busy_b), 0);
    @(negedge sys_clk); start = 1'b0; stop = 1'b0;
    repeat (3) next_sym();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ask_symbol_source.md
ASK_SYMBOL_SOURCE -- requirements
Module: ask_symbol_source

Interface
REQ-001 SHALL have parameter PREAMBLE_LEN, default 8: preamble symbols per frame, range 2..255.
REQ-002 SHALL have parameter FRAME_LEN, default 256: data symbols per frame, range 1..65535.
REQ-003 SHALL have port sys_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sam_clk_en, input, 1 bit: one-cycle sample strobe.
REQ-006 SHALL have port sym_clk_en, input, 1 bit: one-cycle symbol strobe, coincident with every 4th sam_clk_en.
REQ-007 SHALL have port start, input, 1 bit: level request to transmit frames.
REQ-008 SHALL have port stop, input, 1 bit: level request to abort transmission.
REQ-009 SHALL have port x_out, output, 18 bits signed 1s17: sample stream to the pulse-shaping filter.
REQ-010 SHALL have port busy, output, 1 bit: high in PREAMBLE or DATA.
REQ-011 SHALL have port frame_sync, output, 1 bit: one-sample pulse marking the first data symbol of a frame.

Function
REQ-012 SHALL implement FSM states IDLE, PREAMBLE, DATA; state changes only on cycles with sym_clk_en=1.
REQ-013 IDLE->PREAMBLE SHALL occur at sym_clk_en when start=1 and stop=0.
REQ-014 PREAMBLE->DATA SHALL occur after PREAMBLE_LEN symbols have been emitted.
REQ-015 DATA SHALL emit FRAME_LEN symbols, then go to PREAMBLE if start=1, else to IDLE.
REQ-016 stop=1 at sym_clk_en SHALL force IDLE from any state; stop SHALL win over a simultaneous start.
REQ-017 4-ASK Gray map SHALL be 00->-98304, 01->-32768, 11->+32768, 10->+98304.
REQ-018 Preamble symbols SHALL alternate +98304, -98304, starting with +98304.
REQ-019 Data bits SHALL come from a 15-bit PRBS15 LFSR: new bit = lfsr[14]^lfsr[13], shifted in at LSB; seed 15'h7FFF.
REQ-020 The LFSR SHALL advance twice per data symbol; the first new bit SHALL be the symbol MSB.
REQ-021 The LFSR SHALL NOT advance in IDLE or PREAMBLE; it SHALL keep its state across frames.
REQ-022 x_out SHALL update only on sam_clk_en cycles and hold between strobes.
REQ-023 A symbol decided at a sym_clk_en SHALL appear on x_out in that same cycle's register update: 1 sys_clk latency.
REQ-024 x_out SHALL be 0 at every sam_clk_en while in IDLE.
REQ-025 frame_sync SHALL be high from the first data symbol's sym_clk_en update until the next sam_clk_en update.
REQ-026 Symbol counters SHALL clear on every state entry; no wrap-around SHALL be observable at the outputs.

Reset
REQ-027 On reset=1 at a clock edge, the block SHALL set state=IDLE, x_out=0, busy=0, frame_sync=0, counters=0 and LFSR=15'h7FFF.
REQ-028 Reset mid-frame SHALL abort immediately with no partial symbol output.
REQ-029 Reset SHALL take priority over all strobes, start and stop.

Configuration
REQ-030 Macro ZERO_STUFF_EN SHALL select the upsampling mode at compile time.
REQ-031 With ZERO_STUFF_EN defined, the symbol value SHALL appear on the sym_clk_en sample only, and the other 3 samples SHALL be 0 (impulse upsampling).
REQ-032 With ZERO_STUFF_EN undefined, the symbol value SHALL be held for all 4 samples (sample-and-hold).

Verification
REQ-033 Reset, then start=1 with defaults -> first 8 symbols are +98304, -98304 alternating; busy=1.
REQ-034 First data symbol after seed 7FFF -> frame_sync pulses and x_out=-98304 (bits 00).
REQ-035 ZERO_STUFF_EN defined -> x_out reads value,0,0,0 per symbol; undefined -> value repeated 4 times.
REQ-036 start and stop both 1 in IDLE -> stays IDLE; x_out=0; busy=0.
REQ-037 reset pulsed at data symbol 100 -> next cycle x_out=0, busy=0; restart reproduces a bit-identical sequence.
REQ-038 FRAME_LEN=4, start held -> pattern 8 preamble + 4 data symbols repeats, with the LFSR continuing across frames.
